// File: rtl/x_stream_source.sv
// rtl/x_stream_source.sv - serial start/X stimulus source for the ones-detector self-test
module x_stream_source #(
  parameter int TARGET      = 16,
  parameter int CW          = 5,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          go,
  input  logic [15:0]   pattern,
  input  logic          G,
  output logic          start_out,
  output logic          X,
  output logic          busy,
  output logic [CW-1:0] ones_sent,
  output logic          done,
  output logic          err
);

  localparam int            TW           = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TARGET_C     = CW'(TARGET);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, SEND, WAIT_ACK} state_t;

  state_t        state;
  logic [15:0]   shreg;
  logic [TW-1:0] tcnt;
  logic [15:0]   shreg_rot;
  logic [CW-1:0] ones_next;

  // Next rotation of the pattern and the ones count after emitting shreg[0]
  always_comb begin
    shreg_rot = {shreg[0], shreg[15:1]};
    ones_next = shreg[0] ? ones_sent + CW'(1) : ones_sent;
  end

  // Transaction FSM; the edge leaving START emits the first bit, so the SEND
  // state lines up exactly with the cycles on which X carries pattern bits
  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      shreg     <= '0;
      tcnt      <= '0;
      start_out <= 1'b0;
      X         <= 1'b0;
      busy      <= 1'b0;
      ones_sent <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            if (pattern != 16'h0000) begin
              shreg     <= pattern;
              ones_sent <= '0;
              tcnt      <= '0;
              start_out <= 1'b1;
              X         <= 1'b0;
              busy      <= 1'b1;
              state     <= START;
            end else begin
              err <= 1'b1;
            end
          end
        end
        START: begin
          start_out <= 1'b0;
          X         <= shreg[0];
          shreg     <= shreg_rot;
          ones_sent <= ones_next;
          state     <= SEND;
        end
        SEND: begin
          if (ones_sent == TARGET_C) begin
            X     <= 1'b0;
            tcnt  <= '0;
            state <= WAIT_ACK;
          end else begin
            X         <= shreg[0];
            shreg     <= shreg_rot;
            ones_sent <= ones_next;
          end
        end
        WAIT_ACK: begin
          if (G) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tcnt == TIMEOUT_LAST) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_x_stream_source.sv
// tb/tb_x_stream_source.sv - randomized self-checking bench for x_stream_source
module tb_x_stream_source;

  localparam int TARGET      = 16;
  localparam int CW          = 5;
  localparam int ACK_TIMEOUT = 4;

  logic          clock = 1'b0;
  logic          clear;
  logic          go;
  logic [15:0]   pattern;
  logic          G;
  logic          start_out;
  logic          X;
  logic          busy;
  logic [CW-1:0] ones_sent;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;
  int last_ones = 0;

  always #5 clock = ~clock;

  x_stream_source #(.TARGET(TARGET), .CW(CW), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock), .clear(clear), .go(go), .pattern(pattern), .G(G),
    .start_out(start_out), .X(X), .busy(busy), .ones_sent(ones_sent),
    .done(done), .err(err)
  );

  // Fields packed as {start_out, X, busy, done, err, ones_sent}
  function automatic logic [31:0] pack(input logic s, input logic x, input logic b,
                                       input logic d, input logic e, input int o);
    logic [CW-1:0] ov;
    ov = CW'(o);
    return 32'({s, x, b, d, e, ov});
  endfunction

  function automatic logic [31:0] observed();
    return 32'({start_out, X, busy, done, err, ones_sent});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got {s,x,b,d,e,ones}=%b want %b", tag, obs[9:0], exp[9:0]);
    end
  endtask

  // One transaction: ack_k is the WAIT_ACK cycle (1-based) on which G is
  // presented, 0 means never; clear_at >= 0 asserts clear once that many
  // ones have been sent.
  task automatic run_txn(input string tag, input logic [15:0] p,
                         input int ack_k, input int clear_at);
    logic [31:0] exp_q[$];
    int n = 0;
    int i = 0;
    int wstart;
    logic b;
    if (p == 16'h0000) begin
      exp_q.push_back(pack(0, 0, 0, 0, 1, last_ones));
      exp_q.push_back(pack(0, 0, 0, 0, 0, last_ones));
      wstart = 2;
    end else begin
      exp_q.push_back(pack(1, 0, 1, 0, 0, 0));
      while (n < TARGET) begin
        b = p[i % 16];
        n += int'(b);
        exp_q.push_back(pack(0, b, 1, 0, 0, n));
        i++;
      end
      wstart = exp_q.size();
      if (ack_k >= 1 && ack_k <= ACK_TIMEOUT) begin
        for (int w = 0; w < ack_k; w++) exp_q.push_back(pack(0, 0, 1, 0, 0, TARGET));
        exp_q.push_back(pack(0, 0, 0, 1, 0, TARGET));
      end else begin
        for (int w = 0; w < ACK_TIMEOUT; w++) exp_q.push_back(pack(0, 0, 1, 0, 0, TARGET));
        exp_q.push_back(pack(0, 0, 0, 0, 1, TARGET));
      end
      exp_q.push_back(pack(0, 0, 0, 0, 0, TARGET));
      last_ones = TARGET;
    end

    @(posedge clock);
    pattern = p;
    go      = 1'b1;
    G       = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(posedge clock);
      go = 1'b0;
      check(tag, observed(), exp_q[j]);
      if (clear_at >= 0 && j >= 1 && j < wstart && int'(exp_q[j][CW-1:0]) == clear_at) begin
        #1 clear = 1'b1;
        #1 check({tag, "_clear"}, observed(), 32'h0);
        clear     = 1'b0;
        G         = 1'b0;
        last_ones = 0;
        @(posedge clock);
        check({tag, "_after_clear"}, observed(), 32'h0);
        return;
      end
      if (j < wstart) G = 1'($urandom_range(0, 1));
      else            G = (ack_k >= 1 && j == wstart + ack_k - 1);
    end
    G = 1'b0;
  endtask

  initial begin
    logic [15:0] p;
    int          sel;
    clear   = 1'b1;
    go      = 1'b0;
    G       = 1'b0;
    pattern = 16'h0000;
    #12;
    check("reset", observed(), 32'h0);
    @(posedge clock);
    clear = 1'b0;
    @(posedge clock);
    check("idle_after_reset", observed(), 32'h0);

    run_txn("ffff_ack2",   16'hFFFF, 2, -1);
    run_txn("5555_ack1",   16'h5555, 1, -1);
    run_txn("0001_ack3",   16'h0001, 3, -1);
    run_txn("zero_pat",    16'h0000, 0, -1);
    run_txn("ffff_noack",  16'hFFFF, 0, -1);
    run_txn("ack_at_tmo",  16'hA5C3, ACK_TIMEOUT, -1);
    run_txn("ffff_clear5", 16'hFFFF, 2, 5);
    run_txn("after_clear", 16'h00F0, 1, -1);
    run_txn("zero_hold",   16'h0000, 0, -1);

    for (int t = 0; t < 24; t++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0:       p = 16'h0000;
        1:       p = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: p = 16'($urandom);
      endcase
      run_txn($sformatf("rand%0d", t), p, $urandom_range(0, ACK_TIMEOUT + 2),
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, TARGET - 1) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
